// File: rtl/duty_clk_pkg.sv
// rtl/duty_clk_pkg.sv - shared width, config struct and threshold helper for duty_clk_gen
package duty_clk_pkg;

    localparam int DCW = 8;

    typedef struct packed {
        logic [DCW-1:0] period;
        logic [DCW-1:0] high;
    } chan_cfg_t;

    // Count value at which the high phase begins; 0 means the whole period is high.
    function automatic int unsigned hi_thresh(input int unsigned p, input int unsigned h);
        return (h >= p) ? 32'd0 : p - h;
    endfunction

endpackage

// File: rtl/duty_clk_chan.sv
// rtl/duty_clk_chan.sv - one channel: counter, double-buffered config, registered outputs
module duty_clk_chan
    import duty_clk_pkg::*;
#(
    parameter int CW = DCW
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_en,
    input  logic          i_load,
    input  logic [CW-1:0] i_period,
    input  logic [CW-1:0] i_high,
    output logic          o_clk,
    output logic          o_rise,
    output logic          o_pend
);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_pa;
    logic [CW-1:0] r_ha;
    logic [CW-1:0] r_pp;
    logic [CW-1:0] r_hp;
    logic          r_pend;
    logic          r_clk;
    logic          r_rise;

    logic [CW-1:0] w_last;
    logic          w_wrap;
    logic          w_apply;
    logic [CW-1:0] w_pa_n;
    logic [CW-1:0] w_ha_n;
    logic [CW-1:0] w_cnt_n;
    logic [CW-1:0] w_thr;
    logic          w_clk_n;
    logic          w_rise_n;

    assign w_last  = r_pa - CW'(1);
    assign w_wrap  = (r_cnt == w_last);
    assign w_apply = r_pend && (!i_en || (r_pa == '0) || w_wrap);
    assign w_pa_n  = w_apply ? r_pp : r_pa;
    assign w_ha_n  = w_apply ? r_hp : r_ha;

    // Any period boundary, apply or stop restarts the low phase at zero.
    assign w_cnt_n = (!i_en || w_apply || (r_pa == '0) || w_wrap) ? '0 : r_cnt + CW'(1);

    assign w_thr    = CW'(hi_thresh(32'(w_pa_n), 32'(w_ha_n)));
    assign w_clk_n  = i_en && (w_pa_n != '0) && (w_ha_n != '0) && (w_cnt_n >= w_thr);
    // A constant-high config has no edge inside the period, so it never strobes.
    assign w_rise_n = w_clk_n && !r_clk && (w_ha_n < w_pa_n);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt  <= '0;
            r_pa   <= '0;
            r_ha   <= '0;
            r_pp   <= '0;
            r_hp   <= '0;
            r_pend <= 1'b0;
            r_clk  <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_n;
            r_pa   <= w_pa_n;
            r_ha   <= w_ha_n;
            r_clk  <= w_clk_n;
            r_rise <= w_rise_n;
            if (i_load) begin
                r_pp   <= i_period;
                r_hp   <= i_high;
                r_pend <= 1'b1;
            end else if (w_apply) begin
                r_pend <= 1'b0;
            end
        end
    end

    assign o_clk  = r_clk;
    assign o_rise = r_rise;
    assign o_pend = r_pend;

endmodule

// File: rtl/duty_clk_gen.sv
// rtl/duty_clk_gen.sv - multi-channel programmable period/duty clock and strobe generator
module duty_clk_gen
    import duty_clk_pkg::*;
#(
    parameter int NCH = 4,
    parameter int CW  = DCW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH-1:0]    en,
    input  logic [NCH-1:0]    load,
    input  logic [NCH*CW-1:0] period,
    input  logic [NCH*CW-1:0] high,
    output logic [NCH-1:0]    clk_o,
    output logic [NCH-1:0]    rise_o,
    output logic [NCH-1:0]    pend_o
);

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        duty_clk_chan #(
            .CW(CW)
        ) u_chan (
            .i_clk    (clk),
            .i_rst_n  (rst_n),
            .i_en     (en[g]),
            .i_load   (load[g]),
            .i_period (period[g*CW +: CW]),
            .i_high   (high[g*CW +: CW]),
            .o_clk    (clk_o[g]),
            .o_rise   (rise_o[g]),
            .o_pend   (pend_o[g])
        );
    end

endmodule

// File: tb/tb_duty_clk_gen.sv
// tb/tb_duty_clk_gen.sv - randomized and directed self-checking bench for duty_clk_gen
module tb_duty_clk_gen;
    import duty_clk_pkg::*;

    localparam int NCH = 4;
    localparam int CW  = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NCH-1:0]    en;
    logic [NCH-1:0]    load;
    logic [NCH*CW-1:0] period;
    logic [NCH*CW-1:0] high;
    logic [NCH-1:0]    clk_o;
    logic [NCH-1:0]    rise_o;
    logic [NCH-1:0]    pend_o;

    always #5 clk = ~clk;

    duty_clk_gen #(.NCH(NCH), .CW(CW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .load   (load),
        .period (period),
        .high   (high),
        .clk_o  (clk_o),
        .rise_o (rise_o),
        .pend_o (pend_o)
    );

    int n_cmp = 0;
    int n_err = 0;

    int m_pa[NCH], m_ha[NCH], m_pp[NCH], m_hp[NCH], m_cnt[NCH];
    bit m_pend[NCH], m_clk[NCH], m_rise[NCH];
    int hi0, rise0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_pa[c] = 0; m_ha[c] = 0; m_pp[c] = 0; m_hp[c] = 0; m_cnt[c] = 0;
            m_pend[c] = 0; m_clk[c] = 0; m_rise[c] = 0;
        end
    endtask

    // Behavioural view of one rising edge: boundary/apply rules, then the waveform from cnt.
    task automatic model_edge();
        for (int c = 0; c < NCH; c++) begin
            bit e, ld, ap, hi;
            int old_pa;
            e  = en[c];
            ld = load[c];
            old_pa = m_pa[c];
            ap = m_pend[c] && (!e || old_pa == 0 || m_cnt[c] == old_pa - 1);
            if (!e || ap || old_pa == 0) m_cnt[c] = 0;
            else m_cnt[c] = (m_cnt[c] + 1) % old_pa;
            if (ap) begin
                m_pa[c] = m_pp[c];
                m_ha[c] = m_hp[c];
            end
            if (ld) begin
                m_pp[c] = int'(period[c*CW +: CW]);
                m_hp[c] = int'(high[c*CW +: CW]);
                m_pend[c] = 1;
            end else if (ap) begin
                m_pend[c] = 0;
            end
            hi = e && m_pa[c] > 0 && m_ha[c] > 0 && (m_ha[c] >= m_pa[c] || m_cnt[c] >= m_pa[c] - m_ha[c]);
            m_rise[c] = hi && !m_clk[c] && (m_ha[c] < m_pa[c]);
            m_clk[c]  = hi;
        end
    endtask

    task automatic cyc(input int n);
        logic [NCH-1:0] ec, er, ep;
        repeat (n) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            for (int c = 0; c < NCH; c++) begin
                ec[c] = m_clk[c];
                er[c] = m_rise[c];
                ep[c] = m_pend[c];
            end
            chk("clk_o", 32'(clk_o), 32'(ec));
            chk("rise_o", 32'(rise_o), 32'(er));
            chk("pend_o", 32'(pend_o), 32'(ep));
            if (clk_o[0]) hi0++;
            if (rise_o[0]) rise0++;
        end
    endtask

    task automatic set_cfg(input int c, input int p, input int h);
        period[c*CW +: CW] = CW'(p);
        high[c*CW +: CW]   = CW'(h);
    endtask

    task automatic load_one(input int c, input int p, input int h);
        set_cfg(c, p, h);
        load[c] = 1'b1;
        cyc(1);
        load[c] = 1'b0;
    endtask

    task automatic wait_cnt(input int c, input int v);
        int g;
        g = 0;
        while (m_cnt[c] != v && g < 300) begin
            cyc(1);
            g++;
        end
        chk("wait_cnt", 32'(m_cnt[c]), 32'(v));
    endtask

    task automatic window(input string tag, input int n, input int exp_hi, input int exp_rise);
        hi0 = 0;
        rise0 = 0;
        cyc(n);
        chk({tag, "_hi"}, 32'(hi0), 32'(exp_hi));
        chk({tag, "_rise"}, 32'(rise0), 32'(exp_rise));
    endtask

    initial begin
        int len, g;
        chan_cfg_t rcfg[NCH];

        rst_n = 1'b0; en = '0; load = '0; period = '0; high = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_clk", 32'(clk_o), 0);
        chk("rst_rise", 32'(rise_o), 0);
        chk("rst_pend", 32'(pend_o), 0);
        rst_n = 1'b1;

        // Basic 10/4 waveform on channel 0
        en[0] = 1'b1;
        load_one(0, 10, 4);
        cyc(15);
        window("p10h4", 20, 8, 2);

        // Mid-period reload is deferred to the boundary
        wait_cnt(0, 2);
        load_one(0, 5, 2);
        len = 0; g = 0;
        while (pend_o[0] && g < 40) begin
            len++; g++;
            cyc(1);
        end
        chk("pend_len", 32'(len), 7);
        cyc(10);
        window("p5h2", 20, 8, 4);

        // Duty corners
        load_one(0, 10, 0);
        cyc(12);
        window("h0", 20, 0, 0);
        load_one(0, 10, 10);
        cyc(12);
        window("hfull", 20, 20, 0);
        load_one(0, 0, 4);
        cyc(12);
        window("p0", 20, 0, 0);

        // Enable drop and restart
        load_one(0, 10, 4);
        cyc(12);
        wait_cnt(0, 7);
        en[0] = 1'b0;
        cyc(5);
        en[0] = 1'b1;
        len = 0; g = 0;
        while (!clk_o[0] && g < 40) begin
            len++; g++;
            cyc(1);
        end
        chk("restart_low", 32'(len), 6);

        // Last load wins
        cyc(12);
        wait_cnt(0, 1);
        load_one(0, 8, 2);
        cyc(2);
        load_one(0, 6, 3);
        cyc(12);
        window("p6h3", 18, 9, 3);

        // Load in the apply cycle stays pending for a further period
        load_one(0, 10, 4);
        wait_cnt(0, 5);
        load_one(0, 4, 1);
        chk("defer_pend", 32'(pend_o[0]), 1);
        cyc(24);
        window("p4h1", 20, 5, 5);

        // Randomized traffic on all channels
        for (int i = 0; i < 2500; i++) begin
            for (int c = 0; c < NCH; c++) begin
                int p, h;
                if ($urandom_range(63) == 0) en[c] = ~en[c];
                load[c] = ($urandom_range(23) == 0);
                p = ($urandom_range(7) == 0) ? int'($urandom_range(255)) : int'($urandom_range(12));
                h = int'($urandom_range(p + 2));
                if (h > 255) h = 255;
                set_cfg(c, p, h);
            end
            cyc(1);
        end
        load = '0;

        // All channels running, then an asynchronous reset mid-period
        rcfg[0] = '{period: 8'd3, high: 8'd1};
        rcfg[1] = '{period: 8'd4, high: 8'd2};
        rcfg[2] = '{period: 8'd5, high: 8'd2};
        rcfg[3] = '{period: 8'd7, high: 8'd3};
        en = '1;
        for (int c = 0; c < NCH; c++) set_cfg(c, int'(rcfg[c].period), int'(rcfg[c].high));
        load = '1;
        cyc(1);
        load = '0;
        cyc(17);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_clk", 32'(clk_o), 0);
        chk("arst_rise", 32'(rise_o), 0);
        chk("arst_pend", 32'(pend_o), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cyc(10);
        chk("post_rst_clk", 32'(clk_o), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/duty_clk_gen.md
# duty_clk_gen

Synthesisable, parametrised multi-channel clock/strobe generator with programmable period and duty cycle per channel, derived from a single system clock. Each channel divides `clk` by a programmable period P and drives its output high for a programmable H cycles per period. New settings are double-buffered and take effect only at a period boundary, so the outputs never glitch. The block sits beside the bench/SoC clock infrastructure and feeds derived enables, slow clocks and PWM outputs to downstream logic.

## Interface
- `NCH`, 4: number of independent channels.
- `CW`, 8: counter/config width; P and H range 0..2^CW-1.

Ports:
- `clk`  in  1: system clock, all logic on rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `en`  in  NCH: per-channel run enable.
- `load`  in  NCH: per-channel one-cycle strobe; captures the new config into pending.
- `period`  in  NCH*CW: per-channel P; channel i is at bits [i*CW +: CW].
- `high`  in  NCH*CW: per-channel H (high time in cycles), same packing as `period`.
- `clk_o`  out  NCH: generated waveform, registered.
- `rise_o`  out  NCH: one-cycle strobe in the cycle `clk_o` first reads 1 in a period.
- `pend_o`  out  NCH: high while a loaded config has not yet been applied.

## Operation
- Per-channel state:
  - active config (P_a, H_a);
  - pending config (P_p, H_p) with pending flag;
  - counter `cnt` (CW bits).
- Waveform: low phase first, then high.
  - `clk_o` = 1 iff `cnt` >= P_a − H_a (unsigned).
  - `cnt` counts 0..P_a−1, then wraps to 0.
- Duty rules:
  - H_a = 0: output constant 0.
  - H_a >= P_a: output constant 1 and `rise_o` never pulses.
  - P_a = 0: channel stopped; `cnt` held at 0 and `clk_o` = 0.
  - P_a = 1 with H_a >= 1: constant 1.
- `load` in a cycle: P_p, H_p ← `period`, `high` slices and the pending flag is set. A second `load` before apply overwrites the pending values (last wins).
- Apply point, in the cycle where the pending flag is set and any of these holds:
  - `cnt` = P_a−1;
  - `en` = 0;
  - P_a = 0.
- At the apply point: P_a, H_a ← pending; pending flag cleared; `cnt` ← 0.
- `load` in the same cycle as an apply: the incoming value is written to pending and the flag stays set, so the new value applies at the next boundary.
- `en` = 0: `cnt` ← 0 and `clk_o` ← 0. Pending applies immediately. `load` is still accepted.
- `en` 0→1: counting starts from `cnt` = 0 with the current active config.
- Channels are fully independent.

## Timing
- Reset values (all channels):
  - `cnt` = 0, P_a = 0, H_a = 0, pending flag = 0, P_p = 0, H_p = 0;
  - `clk_o` = 0, `rise_o` = 0, `pend_o` = 0.
- Outputs are registered and reflect the `cnt` value of the same cycle. `clk_o` is computed from the next-state count and config.
- Output period is exactly P_a cycles; high time is exactly min(H_a, P_a) cycles.
- `rise_o` is asserted in the first cycle of the high phase. It also asserts on the first cycle of 1 after enable or after an apply where the output was 0 the cycle before.
- `pend_o` rises the cycle after `load` and falls the cycle after the apply.
- Latency with the channel idle (P_a = 0 or `en` = 0):
  - `load` at edge k → apply at edge k+1;
  - first `cnt` = 0 of the new config at edge k+1.
- Reset asserted mid-period clears everything asynchronously. The first period after release starts at `cnt` = 0.

## Structure
- Package `duty_clk_pkg`:
  - default `CW`;
  - `chan_cfg_t` struct {period, high};
  - helper function computing the high-phase threshold P−H (saturates at 0 when H >= P).
- Sub-module `duty_clk_chan`: one channel holding counter, active/pending registers and output registers. The top instantiates it `NCH` times in a generate loop and only slices the buses.

## Test plan
- Channel 0: load P=10, H=4, en=1 → `clk_o` repeats 6 low / 4 high; `rise_o` pulses once per 10 cycles.
- Running at P=10, H=4: load P=5, H=2 mid-period (cnt=3) → old waveform completes through cnt=9; then 3 low / 2 high; `pend_o` is high for exactly 7 cycles.
- Duty corner cases:
  - H=0 → `clk_o` = 0 constant;
  - H=10 with P=10 → `clk_o` = 1 constant, no `rise_o`;
  - P=0 → stopped, `cnt` = 0.
- `en` dropped at cnt=7 then reasserted → `clk_o` = 0 while disabled; restart from `cnt` = 0 with 6 low cycles first.
- Two `load`s before the boundary (P=8/H=2, then P=6/H=3) → only P=6, H=3 is applied. A `load` coincident with the apply cycle is deferred to the next boundary.
- All 4 channels running P=3/4/5/7 with `rst_n` pulsed low asynchronously mid-run → all outputs 0 immediately. After release, all channels are stopped until loaded again.
